// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the HAL memory-port arbiter
package mem_arb_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Width of a counter that must reach max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first request after last wins
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!any && req[idx]) begin
        grant = IW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the HAL memory port, one op in flight
module mem_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
  parameter int DATA_W       = mem_arb_pkg::DATA_W,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic                      memory_read_req,
  output logic                      memory_write_req,
  output logic [ADDR_W-1:0]         memory_addr,
  output logic [DATA_W-1:0]         memory_data_write,
  input  logic [DATA_W-1:0]         memory_data_read,
  input  logic                      memory_busy
);

  import mem_arb_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(BUSY_TIMEOUT);

  state_t        state;
  logic [IW-1:0] cur;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic          pick_any;
  logic          is_write;
  logic [CW-1:0] cnt;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .grant (pick),
    .any   (pick_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      cur               <= '0;
      last_grant        <= IW'(NUM_REQ - 1);
      is_write          <= 1'b0;
      cnt               <= '0;
      req_ack           <= '0;
      req_done          <= '0;
      req_err           <= 1'b0;
      req_rdata         <= '0;
      memory_read_req   <= 1'b0;
      memory_write_req  <= 1'b0;
      memory_addr       <= '0;
      memory_data_write <= '0;
    end else begin
      req_ack          <= '0;
      req_done         <= '0;
      req_err          <= 1'b0;
      memory_read_req  <= 1'b0;
      memory_write_req <= 1'b0;
      case (state)
        IDLE: begin
          // HAL may still be finishing an op orphaned by reset, so wait it out.
          if (!memory_busy && pick_any) begin
            memory_addr       <= req_addr[pick*ADDR_W +: ADDR_W];
            memory_data_write <= req_wdata[pick*DATA_W +: DATA_W];
            is_write          <= req_write[pick];
            req_ack[pick]     <= 1'b1;
            cur               <= pick;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          memory_write_req <= is_write;
          memory_read_req  <= !is_write;
          cnt              <= '0;
          state            <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (memory_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT)) begin
            req_done[cur] <= 1'b1;
            req_err       <= 1'b1;
            last_grant    <= cur;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!memory_busy) begin
            if (!is_write) req_rdata <= memory_data_read;
            req_done[cur] <= 1'b1;
            last_grant    <= cur;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
